// File: rtl/cpu_mc_gpio_if.sv
// cpu_mc_gpio_if
// Memory-side bus of the multi-cycle GPIO CPU: instruction ROM fetch port
// plus the req/ack data-memory port.
//   imem_addr  cpu -> rom  instruction address (registered in the CPU)
//   imem_data  rom -> cpu  instruction word, valid one cycle after imem_addr
//   dmem_req   cpu -> ram  request, held until dmem_ack
//   dmem_we    cpu -> ram  1 = store, 0 = load
//   dmem_addr  cpu -> ram  data address
//   dmem_wdata cpu -> ram  store data
//   dmem_rdata ram -> cpu  load data, sampled on the ack cycle
//   dmem_ack   ram -> cpu  completes the request in the cycle it is high
// Modports: master (CPU side), slave (memory side).
interface cpu_mc_gpio_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
);
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_data;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_addr,
    input  imem_data,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/cpu_mc_gpio.sv
// cpu_mc_gpio
// Parametrised multi-cycle GPIO CPU: 8-entry register file (r0 reads zero),
// synchronised GPIO input, registered GPIO output, external sync ROM and
// req/ack data RAM.
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous, active-high reset
//   gpi    asynchronous GPIO inputs (2-flop synchronised)
//   gpo    registered GPIO outputs, updated only by OUT
//   bus    cpu_mc_gpio_if.master: imem fetch port + dmem req/ack port
//   halted high in HALT
//   err    sticky dmem timeout flag (0 unless DMEM_TIMEOUT_EN is defined)
// Build option: define DMEM_TIMEOUT_EN to abort a data access that is not
// acknowledged within TIMEOUT cycles (drop req, set err, go to HALT).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | imem_addr already holds pc; ROM word arrives for next cycle
// S_EXEC  | decode imem_data, execute / write back or launch a dmem access
// S_MEM   | dmem_req held with stable address/data until dmem_ack
// S_HALT  | halted=1, no further activity until reset
module cpu_mc_gpio #(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int GPI_W   = 8,
  parameter int GPO_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GPI_W-1:0]     gpi,
  output logic [GPO_W-1:0]     gpo,
  cpu_mc_gpio_if.master        bus,
  output logic                 halted,
  output logic                 err
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_JNZ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;
  localparam logic [3:0] OP_OUT  = 4'd10;
  localparam logic [3:0] OP_IN   = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_regs [1:7];
  logic [PC_W-1:0]   r_pc, r_imem_addr;
  logic [GPO_W-1:0]  r_gpo;
  logic [GPI_W-1:0]  r_gpi_s1, r_gpi_s2;
  logic              r_dmem_req, r_dmem_we;
  logic [DATA_W-1:0] r_dmem_addr, r_dmem_wdata;
  logic [2:0]        r_ld_rd;

  // instruction fields
  logic [3:0]        w_op;
  logic              w_imm_sel;
  logic [2:0]        w_rd, w_rx, w_ry;
  logic [15:0]       w_imm;
  assign w_op      = bus.imem_data[31:28];
  assign w_imm_sel = bus.imem_data[27];
  assign w_rd      = bus.imem_data[26:24];
  assign w_rx      = bus.imem_data[23:21];
  assign w_ry      = bus.imem_data[20:18];
  assign w_imm     = bus.imem_data[15:0];
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, bus.imem_data[17:16]};

  // read view of the register file with r0 forced to zero
  logic [DATA_W-1:0] w_rf [0:7];
  assign w_rf[0] = '0;
  for (genvar g = 1; g < 8; g++) begin : g_rf
    assign w_rf[g] = r_regs[g];
  end

  logic [DATA_W-1:0] w_rx_val, w_rd_val, w_op2;
  logic [PC_W-1:0]   w_pc_inc;
  assign w_rx_val = w_rf[w_rx];
  assign w_rd_val = w_rf[w_rd];
  assign w_op2    = w_imm_sel ? DATA_W'(w_imm) : w_rf[w_ry];
  assign w_pc_inc = r_pc + PC_W'(1);

  // w_tc: data access has used up its ack budget (never true without the timeout)
  logic w_tc;
`ifdef DMEM_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;
  assign w_tc = (r_tcnt == '0);
  assign err  = r_err;
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_tc = 1'b0;
  assign err  = 1'b0;
`endif

  logic              w_wb_en, w_pc_load, w_gpo_load, w_mem_start, w_mem_end, w_timeout;
  logic [2:0]        w_wb_idx;
  logic [DATA_W-1:0] w_wb_data;
  logic [PC_W-1:0]   w_pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wb_en     = 1'b0;
    w_wb_idx    = w_rd;
    w_wb_data   = '0;
    w_pc_load   = 1'b0;
    w_pc_nxt    = w_pc_inc;
    w_gpo_load  = 1'b0;
    w_mem_start = 1'b0;
    w_mem_end   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_load   = 1'b1;
        case (w_op)
          OP_AND: begin w_wb_en = 1'b1; w_wb_data = w_rx_val & w_op2; end
          OP_ADD: begin w_wb_en = 1'b1; w_wb_data = w_rx_val + w_op2; end
          OP_SUB: begin w_wb_en = 1'b1; w_wb_data = w_rx_val - w_op2; end
          OP_MOV: begin w_wb_en = 1'b1; w_wb_data = w_op2; end
          OP_IN:  begin w_wb_en = 1'b1; w_wb_data = DATA_W'(r_gpi_s2); end
          OP_JZ:  if (w_rx_val == '0) w_pc_nxt = PC_W'(w_op2);
          OP_JNZ: if (w_rx_val != '0) w_pc_nxt = PC_W'(w_op2);
          OP_JMP: w_pc_nxt = PC_W'(w_op2);
          OP_OUT: w_gpo_load = 1'b1;
          OP_LD, OP_ST: begin
            w_pc_load   = 1'b0;
            w_mem_start = 1'b1;
            w_state_nxt = S_MEM;
          end
          OP_HALT: begin
            w_pc_load   = 1'b0;
            w_state_nxt = S_HALT;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          w_mem_end   = 1'b1;
          w_pc_load   = 1'b1;
          w_state_nxt = S_FETCH;
          if (!r_dmem_we) begin
            w_wb_en   = 1'b1;
            w_wb_idx  = r_ld_rd;
            w_wb_data = bus.dmem_rdata;
          end
        end else if (w_tc) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_HALT;
        end
      end
      S_HALT:  ;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 8; i++) r_regs[i] <= '0;
      r_pc         <= '0;
      r_imem_addr  <= '0;
      r_gpo        <= '0;
      r_gpi_s1     <= '0;
      r_gpi_s2     <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_ld_rd      <= '0;
    end else begin
      r_gpi_s1 <= gpi;
      r_gpi_s2 <= r_gpi_s1;
      // r0 has no storage, so a write to index 0 simply matches nothing
      for (int i = 1; i < 8; i++) begin
        if (w_wb_en && (w_wb_idx == 3'(i))) r_regs[i] <= w_wb_data;
      end
      if (w_pc_load) begin
        r_pc        <= w_pc_nxt;
        r_imem_addr <= w_pc_nxt;
      end
      if (w_gpo_load) r_gpo <= GPO_W'(w_rx_val);
      if (w_mem_start) begin
        r_dmem_req   <= 1'b1;
        r_dmem_we    <= (w_op == OP_ST);
        r_dmem_addr  <= w_rx_val + w_op2;
        r_dmem_wdata <= w_rd_val;
        r_ld_rd      <= w_rd;
      end else if (w_mem_end || w_timeout) begin
        r_dmem_req <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  // down-counter loaded on entry to MEM; terminal count 0 means the
  // current MEM cycle is the last one allowed without an ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= TCNT_W'(TIMEOUT - 1);
      r_err  <= 1'b0;
    end else begin
      if (w_mem_start || w_mem_end)            r_tcnt <= TCNT_W'(TIMEOUT - 1);
      else if ((r_state == S_MEM) && !w_tc)    r_tcnt <= r_tcnt - TCNT_W'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end
`endif

  assign gpo            = r_gpo;
  assign halted         = (r_state == S_HALT);
  assign bus.imem_addr  = r_imem_addr;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
endmodule

// File: tb/tb_cpu_mc_gpio.sv
module tb_cpu_mc_gpio;
  localparam logic [3:0] NOP = 4'd0, AND = 4'd1, ADD = 4'd2, SUB = 4'd3, MOV = 4'd4,
                         LD = 4'd5, ST = 4'd6, JZ = 4'd7, JNZ = 4'd8, JMP = 4'd9,
                         OUT = 4'd10, IN = 4'd11, HLT = 4'd15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] gpi = 8'h00;
  logic [7:0] gpo;
  logic       halted, err;

  cpu_mc_gpio_if #(.PC_W(8), .DATA_W(8)) bus ();

  cpu_mc_gpio dut (
    .clk    (clk),
    .rst    (rst),
    .gpi    (gpi),
    .gpo    (gpo),
    .bus    (bus),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  gpo_q[$];
  logic [16:0] mem_q[$];   // {we, addr, wdata (0 for loads)}
  logic [31:0] rom  [0:255];
  logic [7:0]  dmem [0:255];
  int          ack_dly   = 1;
  bit          ack_never = 1'b0;
  bit          mon_en    = 1'b0;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic isel,
                                      input logic [2:0] rd, input logic [2:0] rx,
                                      input logic [2:0] ry, input logic [15:0] imm);
    return {op, isel, rd, rx, ry, 2'b00, imm};
  endfunction

  // synchronous ROM: address seen mid-cycle, word presented after the edge
  logic [7:0] rom_a;
  always @(negedge clk) rom_a = bus.imem_addr;
  always @(posedge clk) begin
    #1;
    bus.imem_data = rom[rom_a];
  end

  // data RAM: ack raised in the ack_dly-th cycle of a request
  int          mcnt;
  logic [16:0] m_exp, m_got;
  always @(negedge clk) begin
    if (rst || !bus.dmem_req) begin
      mcnt = 0;
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = 8'h00;
    end else begin
      mcnt++;
      bus.dmem_rdata = dmem[bus.dmem_addr];
      bus.dmem_ack   = !ack_never && (mcnt >= ack_dly);
      if (bus.dmem_ack) begin
        m_got = {bus.dmem_we, bus.dmem_addr, bus.dmem_we ? bus.dmem_wdata : 8'h00};
        n_vec++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_txn: got %h, nothing expected", m_got);
        end else begin
          m_exp = mem_q.pop_front();
          if (m_got !== m_exp) begin
            n_err++;
            $display("FAIL mem_txn: got %h, expected %h", m_got, m_exp);
          end
        end
        if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
      end
    end
  end

  // gpo scoreboard: every change of gpo outside reset consumes one entry
  logic [7:0] gpo_prev = 8'h00;
  logic [7:0] g_exp;
  always @(posedge clk) begin
    #1;
    if (rst || !mon_en) gpo_prev = gpo;
    else if (gpo !== gpo_prev) begin
      n_vec++;
      if (gpo_q.size() == 0) begin
        n_err++;
        $display("FAIL gpo_change: got %h, nothing expected", gpo);
      end else begin
        g_exp = gpo_q.pop_front();
        if (gpo !== g_exp) begin
          n_err++;
          $display("FAIL gpo_change: got %h, expected %h", gpo, g_exp);
        end
      end
      gpo_prev = gpo;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(HLT, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
  endtask

  task automatic wait_halt(input int max_cyc);
    int k = 0;
    while (!halted && k < max_cyc) begin
      step(1);
      k++;
    end
    step(1);
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, expected 1", halted, k);
    end
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (gpo_q.size() != 0 || mem_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d gpo / %0d mem expectations left, expected 0 / 0",
               name, gpo_q.size(), mem_q.size());
    end
    gpo_q.delete();
    mem_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec += 5;
    if (gpo !== 8'h00) begin n_err++; $display("FAIL rst_gpo: got %h, expected 00", gpo); end
    if (bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_imem_addr: got %h, expected 00", bus.imem_addr); end
    if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_dmem_req: got %b, expected 0", bus.dmem_req); end
    if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b, expected 0", halted); end
    if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, expected 0", err); end
    step(2);
    n_vec++;
    if (bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL rst_hold_addr: got %h, expected 00", bus.imem_addr); end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    clear_rom();
    rom[0] = enc(MOV, 1'b1, 3'd1, 3'd0, 3'd0, 16'd5);
    rom[1] = enc(ADD, 1'b1, 3'd2, 3'd1, 3'd0, 16'd3);
    rom[2] = enc(OUT, 1'b0, 3'd0, 3'd2, 3'd0, 16'd0);
    rom[3] = enc(HLT, 1'b0, 3'd0, 3'd0, 3'd0, 16'd0);
    gpo_q.push_back(8'h08);
    do_reset();
    step(5);
    n_vec++;
    if (gpo !== 8'h00) begin n_err++; $display("FAIL basic_gpo_early: got %h, expected 00", gpo); end
    step(1);
    n_vec++;
    if (gpo !== 8'h08) begin n_err++; $display("FAIL basic_gpo: got %h, expected 08", gpo); end
    step(1);
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL basic_halt_early: got %b, expected 0", halted); end
    step(1);
    n_vec += 2;
    if (halted !== 1'b1) begin n_err++; $display("FAIL basic_halted: got %b, expected 1", halted); end
    if (bus.imem_addr !== 8'h03) begin n_err++; $display("FAIL basic_addr: got %h, expected 03", bus.imem_addr); end
    step(4);
    n_vec += 3;
    if (bus.imem_addr !== 8'h03) begin n_err++; $display("FAIL basic_addr_hold: got %h, expected 03", bus.imem_addr); end
    if (halted !== 1'b1) begin n_err++; $display("FAIL basic_halt_hold: got %b, expected 1", halted); end
    if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL basic_no_mem: got %b, expected 0", bus.dmem_req); end
    check_drained("basic");
  endtask

  task automatic test_alu_jump();
    clear_rom();
    rom[8'h00] = enc(ADD, 1'b1, 3'd1, 3'd0, 3'd0, 16'h00FF);
    rom[8'h01] = enc(ADD, 1'b1, 3'd1, 3'd1, 3'd0, 16'h0001);
    rom[8'h02] = enc(JZ,  1'b1, 3'd0, 3'd1, 3'd0, 16'h0010);
    rom[8'h10] = enc(JNZ, 1'b1, 3'd0, 3'd1, 3'd0, 16'h0020);
    rom[8'h11] = enc(ADD, 1'b1, 3'd2, 3'd1, 3'd0, 16'h005A);
    rom[8'h12] = enc(OUT, 1'b0, 3'd0, 3'd2, 3'd0, 16'h0);
    rom[8'h13] = enc(MOV, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0077);
    rom[8'h14] = enc(ADD, 1'b1, 3'd3, 3'd0, 3'd0, 16'h0021);
    rom[8'h15] = enc(OUT, 1'b0, 3'd0, 3'd3, 3'd0, 16'h0);
    rom[8'h16] = enc(SUB, 1'b0, 3'd4, 3'd3, 3'd2, 16'h0);
    rom[8'h17] = enc(OUT, 1'b0, 3'd0, 3'd4, 3'd0, 16'h0);
    rom[8'h18] = enc(AND, 1'b0, 3'd5, 3'd4, 3'd2, 16'h0);
    rom[8'h19] = enc(OUT, 1'b0, 3'd0, 3'd5, 3'd0, 16'h0);
    rom[8'h1A] = enc(JMP, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0030);
    rom[8'h1B] = enc(MOV, 1'b1, 3'd7, 3'd0, 3'd0, 16'h0099);
    rom[8'h1C] = enc(OUT, 1'b0, 3'd0, 3'd7, 3'd0, 16'h0);
    rom[8'h30] = enc(MOV, 1'b1, 3'd6, 3'd0, 3'd0, 16'h01F3);
    rom[8'h31] = enc(OUT, 1'b0, 3'd0, 3'd6, 3'd0, 16'h0);
    foreach (gpo_q[i]) gpo_q.delete(i);
    gpo_q.push_back(8'h5A);
    gpo_q.push_back(8'h21);
    gpo_q.push_back(8'hC7);
    gpo_q.push_back(8'h42);
    gpo_q.push_back(8'hF3);
    do_reset();
    step(6);
    n_vec++;
    if (bus.imem_addr !== 8'h10) begin n_err++; $display("FAIL jz_taken: got %h, expected 10", bus.imem_addr); end
    step(2);
    n_vec++;
    if (bus.imem_addr !== 8'h11) begin n_err++; $display("FAIL jnz_not_taken: got %h, expected 11", bus.imem_addr); end
    wait_halt(200);
    check_drained("alu_jump");
  endtask

  task automatic test_mem();
    clear_rom();
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    ack_dly = 3;
    rom[0] = enc(MOV, 1'b1, 3'd3, 3'd0, 3'd0, 16'h00A5);
    rom[1] = enc(ST,  1'b1, 3'd3, 3'd0, 3'd0, 16'h0040);
    rom[2] = enc(LD,  1'b1, 3'd4, 3'd0, 3'd0, 16'h0040);
    rom[3] = enc(OUT, 1'b0, 3'd0, 3'd4, 3'd0, 16'h0);
    rom[4] = enc(ST,  1'b1, 3'd4, 3'd3, 3'd0, 16'h0011);
    rom[5] = enc(LD,  1'b1, 3'd0, 3'd0, 3'd0, 16'h0040);
    rom[6] = enc(ADD, 1'b1, 3'd5, 3'd0, 3'd0, 16'h0012);
    rom[7] = enc(OUT, 1'b0, 3'd0, 3'd5, 3'd0, 16'h0);
    mem_q.push_back({1'b1, 8'h40, 8'hA5});
    mem_q.push_back({1'b0, 8'h40, 8'h00});
    mem_q.push_back({1'b1, 8'hB6, 8'hA5});
    mem_q.push_back({1'b0, 8'h40, 8'h00});
    gpo_q.push_back(8'hA5);
    gpo_q.push_back(8'h12);
    do_reset();
    step(4);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata} !== {1'b1, 1'b1, 8'h40, 8'hA5}) begin
        n_err++;
        $display("FAIL st_hold_c%0d: req/we/addr/wdata %b/%b/%h/%h, expected 1/1/40/a5",
                 c, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
      end
      step(1);
    end
    n_vec++;
    if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL st_req_drop: got %b, expected 0", bus.dmem_req); end
    wait_halt(300);
    n_vec++;
    if (dmem[8'hB6] !== 8'hA5) begin n_err++; $display("FAIL st_indexed: mem[b6]=%h, expected a5", dmem[8'hB6]); end
    check_drained("mem");
    ack_dly = 1;
  endtask

  task automatic test_gpi();
    clear_rom();
    rom[0] = enc(NOP, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[1] = enc(NOP, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[2] = enc(NOP, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
    rom[3] = enc(IN,  1'b0, 3'd6, 3'd0, 3'd0, 16'h0);
    rom[4] = enc(OUT, 1'b0, 3'd0, 3'd6, 3'd0, 16'h0);
    rom[5] = enc(IN,  1'b0, 3'd6, 3'd0, 3'd0, 16'h0);
    rom[6] = enc(OUT, 1'b0, 3'd0, 3'd6, 3'd0, 16'h0);
    gpi = 8'h11;
    gpo_q.push_back(8'h11);
    gpo_q.push_back(8'h3C);
    do_reset();
    step(7);
    gpi = 8'h3C;
    wait_halt(100);
    check_drained("gpi");
  endtask

  task automatic test_reset_mid();
    clear_rom();
    ack_never = 1'b1;
    rom[0] = enc(MOV, 1'b1, 3'd1, 3'd0, 3'd0, 16'h0033);
    rom[1] = enc(OUT, 1'b0, 3'd0, 3'd1, 3'd0, 16'h0);
    rom[2] = enc(LD,  1'b1, 3'd2, 3'd0, 3'd0, 16'h0020);
    gpo_q.push_back(8'h33);
    do_reset();
    step(8);
    n_vec++;
    if ({bus.dmem_req, bus.dmem_addr} !== {1'b1, 8'h20}) begin
      n_err++;
      $display("FAIL mid_req_up: req/addr %b/%h, expected 1/20", bus.dmem_req, bus.dmem_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec += 4;
    if (bus.dmem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_async: got %b, expected 0", bus.dmem_req); end
    if (gpo !== 8'h00) begin n_err++; $display("FAIL mid_gpo: got %h, expected 00", gpo); end
    if (bus.imem_addr !== 8'h00) begin n_err++; $display("FAIL mid_pc: got %h, expected 00", bus.imem_addr); end
    if (halted !== 1'b0) begin n_err++; $display("FAIL mid_halted: got %b, expected 0", halted); end
    gpo_q.push_back(8'h33);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(2);
    n_vec++;
    if (bus.imem_addr !== 8'h01) begin n_err++; $display("FAIL mid_refetch: got %h, expected 01", bus.imem_addr); end
    step(2);
    n_vec++;
    if (gpo !== 8'h33) begin n_err++; $display("FAIL mid_rerun_gpo: got %h, expected 33", gpo); end
    step(1);
    check_drained("reset_mid");
  endtask

  task automatic test_timeout();
    clear_rom();
    ack_never = 1'b1;
    rom[0] = enc(MOV, 1'b1, 3'd2, 3'd0, 3'd0, 16'h005C);
    rom[1] = enc(LD,  1'b1, 3'd2, 3'd0, 3'd0, 16'h0030);
    rom[2] = enc(OUT, 1'b0, 3'd0, 3'd2, 3'd0, 16'h0);
    do_reset();
    step(4);
    n_vec++;
    if (bus.dmem_req !== 1'b1) begin n_err++; $display("FAIL to_req_up: got %b, expected 1", bus.dmem_req); end
`ifdef DMEM_TIMEOUT_EN
    step(15);
    n_vec++;
    if ({bus.dmem_req, err} !== 2'b10) begin
      n_err++;
      $display("FAIL to_last_wait: req/err %b/%b, expected 1/0", bus.dmem_req, err);
    end
    step(1);
    n_vec++;
    if ({bus.dmem_req, err, halted} !== 3'b011) begin
      n_err++;
      $display("FAIL to_abort: req/err/halted %b/%b/%b, expected 0/1/1", bus.dmem_req, err, halted);
    end
    step(4);
    n_vec++;
    if ({gpo, err} !== {8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL to_sticky: gpo/err %h/%b, expected 00/1", gpo, err);
    end
`else
    step(20);
    n_vec++;
    if ({bus.dmem_req, bus.dmem_addr, err, halted} !== {1'b1, 8'h30, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL no_timeout: req/addr/err/halted %b/%h/%b/%b, expected 1/30/0/0",
               bus.dmem_req, bus.dmem_addr, err, halted);
    end
`endif
    check_drained("timeout");
    do_reset();
    ack_never = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu_jump();
    test_mem();
    test_gpi();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cpu_mc_gpio.md
Name: cpu_mc_gpio

Overview:
Parametrised multi-cycle successor of the 8-bit GPIO CPU. It adds the following over the previous generation:
- configurable data and PC width;
- a register file with r0 hardwired to zero;
- a synchronised GPIO input;
- a store instruction;
- a req/ack handshake to external data memory;
- a HALT state.

Instruction ROM and data RAM sit outside the block. The block sits between the board GPIO pins and the memories.

Parameters:
DATA_W, 8, register/ALU/data-bus width (4..32)
PC_W, 8, program counter and imem address width
GPI_W, 8, GPIO input width
GPO_W, 8, GPIO output width
TIMEOUT, 16, dmem ack timeout in cycles (used only with DMEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
gpi  in  GPI_W  asynchronous GPIO inputs
gpo  out  GPO_W  registered GPIO outputs
imem_addr  out  PC_W  instruction address, registered
imem_data  in  32  instruction word; synchronous ROM, valid one cycle after imem_addr
dmem_req  out  1  data-memory request
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr  out  DATA_W  data address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  load data, sampled on the ack cycle
dmem_ack  in  1  request completes on the cycle it is high while dmem_req is high
halted  out  1  high in HALT state
err  out  1  sticky timeout flag; constant 0 without DMEM_TIMEOUT_EN

Behaviour:
- Reset (async, rst=1):
  - r1..r7, pc, gpo, imem_addr all 0.
  - dmem_req=0, halted=0, err=0, state=FETCH.
  - Outputs drop immediately, including mid-transaction.
- Instruction fields:
  - [31:28] opcode
  - [27] imm_sel
  - [26:24] rd
  - [23:21] rx
  - [20:18] ry
  - [15:0] imm
- Operand op2 = imm_sel ? imm : R[ry]. imm is zero-extended or truncated to DATA_W.
- Register rules:
  - r0 always reads 0; writes to it are discarded.
  - r1..r7 are general-purpose.
- Opcodes:
  - 0 NOP
  - 1 AND: rd=rx&op2
  - 2 ADD: rd=rx+op2
  - 3 SUB: rd=rx-op2
  - 4 MOV: rd=op2
  - 5 LD: rd=mem[rx+op2]
  - 6 ST: mem[rx+op2]=R[rd]
  - 7 JZ: if R[rx]==0, pc=op2
  - 8 JNZ: if R[rx]!=0, pc=op2
  - 9 JMP: pc=op2
  - 10 OUT: gpo=R[rx]
  - 11 IN: rd=gpi_sync
  - 15 HALT
  - 12-14 execute as NOP.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^DATA_W; no flags are kept.
  - Jump target is op2[PC_W-1:0].
  - pc+1 wraps at 2^PC_W.
  - OUT/IN zero-extend or truncate between widths.
- gpi passes through a 2-flop synchroniser. IN returns the value that was on the pins at least 2 cycles earlier.
- FSM states:
  - FETCH: imem_addr=pc is already registered; go to EXEC. (1 cycle)
  - EXEC: latch imem_data and execute.
    - ALU, jump, IN, OUT and NOP: write back, update pc (target or pc+1), load imem_addr with the new pc, go to FETCH. These take 2 cycles per instruction.
    - LD/ST: register dmem_addr/dmem_we/dmem_wdata, assert dmem_req, go to MEM.
    - HALT: go to HALT; pc is not advanced.
  - MEM: hold dmem_req and all dmem outputs stable until dmem_ack=1.
    - On the ack cycle: LD writes dmem_rdata to rd; pc=pc+1; dmem_req=0 on the next cycle; go to FETCH.
    - dmem_ack outside MEM is ignored.
  - HALT: halted=1. Stays until reset. gpo is held; no memory activity.
- gpo changes only on the clock edge ending EXEC of an OUT instruction.
- LD with rd=r0 still performs the bus transaction; the result is discarded.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: a counter runs in MEM. If dmem_ack has not arrived after TIMEOUT cycles, the following happen in that cycle:
  - drop dmem_req;
  - set err=1;
  - leave registers unchanged;
  - go to HALT.
  - The counter clears on ack and on reset.
- Undefined: MEM waits indefinitely; err is tied to 0 and no counter logic is built.

Test Plan:
- Reset then ROM {MOV r1,#5; ADD r2,r1,#3; OUT r2; HALT} -> gpo=8 after the 3rd instruction; halted=1 by cycle 8; imem_addr stops at 3.
- ADD r1,r0,#0xFF then ADD r1,r1,#1 (DATA_W=8) -> r1=0x00. JZ r1,#0x10 is taken and imem_addr=0x10. Then JNZ r1,#0x20 is not taken, giving pc=0x11.
- ST r3 (=0xA5) to [r0+#0x40] with ack delayed 3 cycles -> req held 3 cycles with addr=0x40, we=1, wdata=0xA5 stable. Then LD r4,[#0x40] with ack returning 0xA5 -> r4=0xA5.
- gpi driven 0x3C, then IN r6 issued 1 cycle later -> r6 holds the old value. IN issued ≥2 cycles later -> r6=0x3C.
- rst asserted while in MEM with dmem_req=1 -> dmem_req falls the same cycle without waiting for a clock edge. After release: pc=0, gpo=0, fetch restarts at address 0.
- With DMEM_TIMEOUT_EN and TIMEOUT=16, LD and ack never asserted -> after 16 cycles dmem_req=0, err=1, halted=1, rd unchanged.
